// File: rtl/conv_compute_filter_mc_pkg.sv
// Shared width helpers, pipeline side-band type and output clamp for the conv filter engine.
package conv_compute_filter_mc_pkg;

    // Bias travels down the pipeline sign-extended to this width (BIAS_WIDTH must not exceed it).
    localparam int unsigned BIAS_MAX_W = 32;

    // Per-stage side-band: beat valid, group position flags and the bias sampled with the beat.
    typedef struct packed {
        logic                         valid;
        logic                         first;
        logic                         last;
        logic signed [BIAS_MAX_W-1:0] bias;
    } side_t;

    function automatic int unsigned prod_w(input int unsigned pixel_w, input int unsigned weight_w);
        return pixel_w + weight_w + 1;
    endfunction

    function automatic int unsigned row_w(input int unsigned prod, input int unsigned cols);
        return prod + $clog2(cols);
    endfunction

    function automatic int unsigned sum_w(input int unsigned prod, input int unsigned taps);
        return prod + $clog2(taps);
    endfunction

    function automatic int unsigned acc_w(input int unsigned sum, input int unsigned chans);
        return sum + $clog2(chans) + 1;
    endfunction

    function automatic int unsigned fin_w(input int unsigned acc, input int unsigned bias_w);
        return ((acc > bias_w) ? acc : bias_w) + 1;
    endfunction

    // Optional ReLU followed by saturation to a signed ow-bit range.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                    input int unsigned        ow,
                                                    input logic               relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (relu && (v < 64'sd0)) return 64'sd0;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_compute_filter_mc_if.sv
// Beat-in / result-out stream bundle of the conv filter engine.
// Window and weight vectors are row-major: tap r*COLS+c occupies bits [(r*COLS+c)*W +: W].
interface conv_compute_filter_mc_if #(
    parameter int unsigned NUM_TAPS     = 25,
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned BIAS_WIDTH   = 16,
    parameter int unsigned CHAN_W       = 4,
    parameter int unsigned OUTPUT_WIDTH = 24
);
    logic                              flush_i;
    logic                              in_valid_i;
    logic                              in_ready_o;
    logic [NUM_TAPS*PIXEL_WIDTH-1:0]   pxl_vals_i;
    logic [NUM_TAPS*WEIGHT_WIDTH-1:0]  weight_vals_i;
    logic signed [BIAS_WIDTH-1:0]      bias_i;
    logic [CHAN_W-1:0]                 chan_idx_o;
    logic                              out_valid_o;
    logic                              out_ready_i;
    logic signed [OUTPUT_WIDTH-1:0]    out_data_o;

    modport master (
        output flush_i, in_valid_i, pxl_vals_i, weight_vals_i, bias_i, out_ready_i,
        input  in_ready_o, chan_idx_o, out_valid_o, out_data_o
    );

    modport slave (
        input  flush_i, in_valid_i, pxl_vals_i, weight_vals_i, bias_i, out_ready_i,
        output in_ready_o, chan_idx_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/conv_compute_filter_mc_row_mac.sv
// One window row: FILTER_COLS unsigned-by-signed multipliers (S1) and their row sum (S2).
module conv_row_mac
    import conv_compute_filter_mc_pkg::*;
#(
    parameter int unsigned FILTER_COLS  = 5,
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned WEIGHT_WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    ce,
    input  logic [FILTER_COLS*PIXEL_WIDTH-1:0]      pxl_row,
    input  logic [FILTER_COLS*WEIGHT_WIDTH-1:0]     wgt_row,
    output logic signed [row_w(prod_w(PIXEL_WIDTH, WEIGHT_WIDTH), FILTER_COLS)-1:0] row_sum
);
    localparam int unsigned PROD_W = prod_w(PIXEL_WIDTH, WEIGHT_WIDTH);
    localparam int unsigned ROW_W  = row_w(PROD_W, FILTER_COLS);

    logic signed [PROD_W-1:0] prod_d [FILTER_COLS];
    logic signed [PROD_W-1:0] prod_q [FILTER_COLS];
    logic signed [ROW_W-1:0]  sum_d;

    // Pixel is zero-extended so the product keeps the weight's sign.
    always_comb begin
        for (int unsigned c = 0; c < FILTER_COLS; c++) begin
            prod_d[c] = PROD_W'($signed({1'b0, pxl_row[c*PIXEL_WIDTH +: PIXEL_WIDTH]}))
                      * PROD_W'($signed(wgt_row[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
        end
    end

    // Adder tree over the registered products of this row.
    always_comb begin
        sum_d = '0;
        for (int unsigned c = 0; c < FILTER_COLS; c++) begin
            sum_d = sum_d + ROW_W'(prod_q[c]);
        end
    end

    // S1 product and S2 row-sum registers, frozen while ce is low.
    always_ff @(posedge clk) begin
        if (ce) begin
            prod_q  <= prod_d;
            row_sum <= sum_d;
        end
    end

endmodule

// File: rtl/conv_compute_filter_mc.sv
// Pipelined KxK multi-channel convolution for one output pixel: per-row MACs (S1/S2),
// row total (S3), channel accumulation with bias, ReLU and saturation (S4).
module conv_compute_filter_mc
    import conv_compute_filter_mc_pkg::*;
#(
    parameter int unsigned FILTER_ROWS  = 5,
    parameter int unsigned FILTER_COLS  = 5,
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned NUM_CHANNELS = 6,
    parameter int unsigned BIAS_WIDTH   = 16,
    parameter int unsigned OUTPUT_WIDTH = 24,
    parameter bit          RELU_EN      = 1'b1
) (
    input  logic                   conv_filt_clk,
    input  logic                   conv_filt_rst_b,
    conv_compute_filter_mc_if.slave bus
);
    localparam int unsigned NUM_TAPS = FILTER_ROWS * FILTER_COLS;
    localparam int unsigned PROD_W   = prod_w(PIXEL_WIDTH, WEIGHT_WIDTH);
    localparam int unsigned ROW_W    = row_w(PROD_W, FILTER_COLS);
    localparam int unsigned SUM_W    = sum_w(PROD_W, NUM_TAPS);
    localparam int unsigned ACC_W    = acc_w(SUM_W, NUM_CHANNELS);
    localparam int unsigned FIN_W    = fin_w(ACC_W, BIAS_WIDTH);
    localparam int unsigned CHAN_W   = $clog2(NUM_CHANNELS) + 1;
    localparam int unsigned ROW_PX_W = FILTER_COLS * PIXEL_WIDTH;
    localparam int unsigned ROW_WT_W = FILTER_COLS * WEIGHT_WIDTH;

    logic                     ce;
    logic                     chan_last;
    side_t                    s1;
    side_t                    s2;
    side_t                    s3;
    logic signed [ROW_W-1:0]  row_sum [FILTER_ROWS];
    logic signed [SUM_W-1:0]  s2_total;
    logic signed [SUM_W-1:0]  s3_sum;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [FIN_W-1:0]  fin;
    logic [CHAN_W-1:0]        chan_idx;
    logic                     out_valid;
    logic signed [OUTPUT_WIDTH-1:0] out_data;

    // A held result or a flush freezes the whole pipeline.
    assign ce        = !(out_valid && !bus.out_ready_i) && !bus.flush_i;
    assign chan_last = (chan_idx == CHAN_W'(NUM_CHANNELS - 1));

    assign bus.in_ready_o  = ce;
    assign bus.chan_idx_o  = chan_idx;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;

    for (genvar r = 0; r < FILTER_ROWS; r++) begin : g_row
        conv_row_mac #(
            .FILTER_COLS  (FILTER_COLS),
            .PIXEL_WIDTH  (PIXEL_WIDTH),
            .WEIGHT_WIDTH (WEIGHT_WIDTH)
        ) u_row (
            .clk     (conv_filt_clk),
            .ce      (ce),
            .pxl_row (bus.pxl_vals_i[r*ROW_PX_W +: ROW_PX_W]),
            .wgt_row (bus.weight_vals_i[r*ROW_WT_W +: ROW_WT_W]),
            .row_sum (row_sum[r])
        );
    end

    // Window total from the registered row sums.
    always_comb begin
        s2_total = '0;
        for (int unsigned r = 0; r < FILTER_ROWS; r++) begin
            s2_total = s2_total + SUM_W'(row_sum[r]);
        end
    end

    // Channel accumulation and final biased value for the beat leaving S3.
    always_comb begin
        acc_base = s3.first ? '0 : acc;
        acc_next = acc_base + ACC_W'(s3_sum);
        fin      = FIN_W'(acc_next) + FIN_W'($signed(s3.bias));
    end

    // S3 data register; its valid lives in the side-band.
    always_ff @(posedge conv_filt_clk) begin
        if (ce) begin
            s3_sum <= s2_total;
        end
    end

    // Side-band pipeline, channel counter, accumulator and output register.
    always_ff @(posedge conv_filt_clk) begin
        if (!conv_filt_rst_b) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            chan_idx  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (bus.flush_i) begin
            s1.valid  <= 1'b0;
            s2.valid  <= 1'b0;
            s3.valid  <= 1'b0;
            chan_idx  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            s1.valid <= bus.in_valid_i;
            s1.first <= (chan_idx == '0);
            s1.last  <= chan_last;
            s1.bias  <= BIAS_MAX_W'(bus.bias_i);
            s2       <= s1;
            s3       <= s2;
            if (bus.in_valid_i) begin
                chan_idx <= chan_last ? '0 : chan_idx + CHAN_W'(1);
            end
            if (s3.valid) begin
                acc <= acc_next;
            end
            // ce implies any previous result was consumed, so valid simply follows a new result.
            out_valid <= s3.valid && s3.last;
            if (s3.valid && s3.last) begin
                out_data <= OUTPUT_WIDTH'(sat_relu(64'(fin), OUTPUT_WIDTH, RELU_EN));
            end
        end
    end

endmodule

// File: tb/tb_conv_compute_filter_mc.sv
// Directed bench: three engines (ReLU/24b, linear/24b, linear/16b) share one stimulus stream.
module tb_conv_compute_filter_mc;
    localparam int unsigned NT  = 25;
    localparam int unsigned NCH = 6;

    typedef struct {
        logic [7:0]         pxl;
        logic [7:0]         wgt;
        logic signed [15:0] bias;
        longint             exp_a;
        longint             exp_b;
        longint             exp_c;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_b;
    logic               flush;
    logic               in_valid;
    logic               out_ready;
    logic [NT*8-1:0]    pxl;
    logic [NT*8-1:0]    wgt;
    logic signed [15:0] bias;
    int                 n_checks = 0;
    int                 n_fail   = 0;
    vec_t               vecs [8];
    int                 lat;
    int                 cnt;
    int                 nres;
    longint             r0;
    longint             r1;
    logic [NT*8-1:0]    pv;
    logic [NT*8-1:0]    wv;

    always #5 clk = ~clk;

    conv_compute_filter_mc_if #(.NUM_TAPS(NT), .PIXEL_WIDTH(8), .WEIGHT_WIDTH(8),
        .BIAS_WIDTH(16), .CHAN_W(4), .OUTPUT_WIDTH(24)) bus_a ();
    conv_compute_filter_mc_if #(.NUM_TAPS(NT), .PIXEL_WIDTH(8), .WEIGHT_WIDTH(8),
        .BIAS_WIDTH(16), .CHAN_W(4), .OUTPUT_WIDTH(24)) bus_b ();
    conv_compute_filter_mc_if #(.NUM_TAPS(NT), .PIXEL_WIDTH(8), .WEIGHT_WIDTH(8),
        .BIAS_WIDTH(16), .CHAN_W(4), .OUTPUT_WIDTH(16)) bus_c ();

    assign bus_a.flush_i = flush;    assign bus_b.flush_i = flush;    assign bus_c.flush_i = flush;
    assign bus_a.in_valid_i = in_valid; assign bus_b.in_valid_i = in_valid; assign bus_c.in_valid_i = in_valid;
    assign bus_a.pxl_vals_i = pxl;   assign bus_b.pxl_vals_i = pxl;   assign bus_c.pxl_vals_i = pxl;
    assign bus_a.weight_vals_i = wgt; assign bus_b.weight_vals_i = wgt; assign bus_c.weight_vals_i = wgt;
    assign bus_a.bias_i = bias;      assign bus_b.bias_i = bias;      assign bus_c.bias_i = bias;
    assign bus_a.out_ready_i = out_ready; assign bus_b.out_ready_i = out_ready; assign bus_c.out_ready_i = out_ready;

    conv_compute_filter_mc #(.RELU_EN(1'b1)) dut_a (
        .conv_filt_clk(clk), .conv_filt_rst_b(rst_b), .bus(bus_a));
    conv_compute_filter_mc #(.RELU_EN(1'b0)) dut_b (
        .conv_filt_clk(clk), .conv_filt_rst_b(rst_b), .bus(bus_b));
    conv_compute_filter_mc #(.OUTPUT_WIDTH(16), .RELU_EN(1'b0)) dut_c (
        .conv_filt_clk(clk), .conv_filt_rst_b(rst_b), .bus(bus_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [NT*8-1:0] p, input logic [NT*8-1:0] w,
                             input logic signed [15:0] b);
        logic acc;
        pxl = p; wgt = w; bias = b; in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            #1;
            acc = bus_a.in_ready_o;
            @(posedge clk);
            #1;
        end
        check("beat_accept", acc, 1);
        in_valid = 1'b0;
    endtask

    // Full group; non-last beats carry a junk bias that must be ignored.
    task automatic send_group_vec(input logic [NT*8-1:0] p, input logic [NT*8-1:0] w,
                                  input logic signed [15:0] b);
        for (int i = 0; i < NCH; i++) begin
            send_beat(p, w, (i == NCH - 1) ? b : 16'sd12345);
        end
    endtask

    task automatic send_group(input logic [7:0] p, input logic [7:0] w, input logic signed [15:0] b);
        send_group_vec({NT{p}}, {NT{w}}, b);
    endtask

    // Called right after the last beat's accepting edge.
    task automatic expect_result(input string name, input longint ea, input longint eb, input longint ec);
        int l;
        l = 1;
        while (!bus_a.out_valid_o && l < 20) begin
            step();
            l++;
        end
        check({name, "_latency"}, l, 4);
        check({name, "_a"}, bus_a.out_data_o, ea);
        check({name, "_b"}, bus_b.out_data_o, eb);
        check({name, "_c"}, bus_c.out_data_o, ec);
        check({name, "_c_valid"}, bus_c.out_valid_o, 1);
        step();
        check({name, "_valid_drop"}, bus_a.out_valid_o, 0);
        check({name, "_chan_wrap"}, bus_a.chan_idx_o, 0);
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus_a.out_valid_o) c++;
        end
        step();
    endtask

    // Holds out_ready low for 5 cycles of the first result, then collects two results.
    task automatic stall_monitor(output longint q0, output longint q1, output int n);
        int     stall;
        longint held;
        stall = 0; held = 0; n = 0; q0 = -1; q1 = -1;
        for (int cyc = 0; cyc < 200 && n < 2; cyc++) begin
            @(negedge clk);
            if (bus_a.out_valid_o) begin
                if (!out_ready) begin
                    if (stall == 0) held = bus_a.out_data_o;
                    else check("stall_hold", bus_a.out_data_o, held);
                    check("stall_in_ready", bus_a.in_ready_o, 0);
                    stall++;
                    if (stall == 5) begin
                        out_ready = 1'b1;
                        q0 = held;
                        n = 1;
                    end
                end else begin
                    if (n == 1) q1 = bus_a.out_data_o;
                    n++;
                end
            end
        end
        check("stall_cycles", stall, 5);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_b = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pxl = '0; wgt = '0; bias = '0;

        vecs[0] = '{8'd1,   8'h01, 16'sd0,      150,      150,      150};
        vecs[1] = '{8'd255, 8'h80, 16'sd0,      0,        -4896000, -32768};
        vecs[2] = '{8'd255, 8'h7f, 16'sd0,      4857750,  4857750,  32767};
        vecs[3] = '{8'd1,   8'h01, -16'sd200,   0,        -50,      -50};
        vecs[4] = '{8'd1,   8'hff, 16'h8000,    0,        -32918,   -32768};
        vecs[5] = '{8'd255, 8'h7f, 16'sd32767,  4890517,  4890517,  32767};
        vecs[6] = '{8'd0,   8'h05, 16'sd100,    100,      100,      100};
        vecs[7] = '{8'd3,   8'hfe, 16'sd800,    0,        -100,     -100};

        repeat (3) step();
        check("rst_out_valid", bus_a.out_valid_o, 0);
        check("rst_out_data",  bus_a.out_data_o, 0);
        check("rst_chan_idx",  bus_a.chan_idx_o, 0);
        check("rst_in_ready",  bus_a.in_ready_o, 1);
        rst_b = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            send_group(vecs[i].pxl, vecs[i].wgt, vecs[i].bias);
            expect_result($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c);
        end

        // Distinct values per channel: 25*(1+2+..+6).
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("ramp_chan%0d", k), bus_a.chan_idx_o, k);
            send_beat({NT{8'(k + 1)}}, {NT{8'h01}}, (k == NCH - 1) ? 16'sd0 : 16'sd12345);
        end
        expect_result("ramp", 525, 525, 525);

        // Distinct values per tap: pixel=t, weight=+1 on even taps, -1 on odd taps -> 12 per beat.
        for (int t = 0; t < NT; t++) begin
            pv[t*8 +: 8] = 8'(t);
            wv[t*8 +: 8] = (t % 2 == 1) ? 8'hff : 8'h01;
        end
        send_group_vec(pv, wv, 16'sd0);
        expect_result("taps", 72, 72, 72);

        // Back-to-back groups with a 5-cycle downstream stall on the first result.
        out_ready = 1'b0;
        fork
            begin
                send_group(8'd1, 8'h01, 16'sd0);
                send_group(8'd2, 8'h01, 16'sd0);
            end
            stall_monitor(r0, r1, nres);
        join
        out_ready = 1'b1;
        check("b2b_count",  nres, 2);
        check("b2b_first",  r0, 150);
        check("b2b_second", r1, 300);
        step();

        // Flush after three beats of a group.
        for (int k = 0; k < 3; k++) send_beat({NT{8'd1}}, {NT{8'h01}}, 16'sd12345);
        check("flush_pre_chan", bus_a.chan_idx_o, 3);
        flush = 1'b1;
        @(negedge clk);
        #1;
        check("flush_in_ready", bus_a.in_ready_o, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_chan", bus_a.chan_idx_o, 0);
        check("flush_valid", bus_a.out_valid_o, 0);
        send_group(8'd1, 8'h01, 16'sd0);
        expect_result("after_flush", 150, 150, 150);
        count_valid(10, cnt);
        check("after_flush_extra", cnt, 0);

        // Flush while a complete group's last beat is still in flight: its result must vanish.
        send_group(8'd2, 8'h01, 16'sd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        count_valid(12, cnt);
        check("flush_inflight_drop", cnt, 0);
        send_group(8'd1, 8'h01, 16'sd0);
        expect_result("after_flush2", 150, 150, 150);

        // Reset mid-group.
        for (int k = 0; k < 3; k++) send_beat({NT{8'd1}}, {NT{8'h01}}, 16'sd12345);
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        check("midrst_chan", bus_a.chan_idx_o, 0);
        check("midrst_valid", bus_a.out_valid_o, 0);
        check("midrst_data", bus_a.out_data_o, 0);
        send_group(8'd1, 8'h01, 16'sd0);
        expect_result("after_rst", 150, 150, 150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
